rf_sequencer: RTL and testbench

RF_SEQUENCER -- requirements
Module: rf_sequencer

---
 rtl/rf_sequencer_pkg.sv | 30 +++
 rtl/rf_alu.sv | 36 +++
 rtl/rf_sequencer.sv | 148 ++++++++++++++
 tb/tb_rf_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sequencer_pkg.sv
// Shared definitions for the register-file sequencer: widths, opcodes and FSM states.
package rf_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_MOV = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Only the arithmetic and logic ops update the zero/carry flags.
    function automatic logic is_flag_op(input opcode_e op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
    endfunction

endpackage

// File: rtl/rf_alu.sv
// Combinational datapath: produces the write-back value and flags for one opcode.
module rf_alu
    import rf_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] value,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    // The extra top bit carries the ADD carry-out or the SUB borrow.
    always_comb begin
        wide = '0;
        unique case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_LDI:  wide = {1'b0, imm};
            OP_MOV:  wide = {1'b0, a};
            default: wide = '0;
        endcase
        value = wide[DATA_W-1:0];
        carry = wide[DATA_W];
        zero  = (wide[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/rf_sequencer.sv
// Four-state sequencer driving an external register file through READ, EXEC and WRITE.
module rf_sequencer
    import rf_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] srca,
    input  logic [ADDR_W-1:0] srcb,
    input  logic [DATA_W-1:0] imm,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_xaddr,
    output logic [ADDR_W-1:0] rf_aaddr,
    output logic [ADDR_W-1:0] rf_baddr,
    output logic [DATA_W-1:0] rf_x,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              busy
);

    state_e            state_q, state_d;
    opcode_e           op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] srca_q, srca_d;
    logic [ADDR_W-1:0] srcb_q, srcb_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] alu_value;
    logic              alu_carry;
    logic              alu_zero;

    rf_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op    (op_q),
        .a     (rf_a),
        .b     (rf_b),
        .imm   (imm_q),
        .value (alu_value),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            dst_q    <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            imm_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            imm_q    <= imm_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    // Instruction fields are only sampled in IDLE, so mid-operation input changes are ignored.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        imm_d    = imm_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d   = opcode_e'(opcode);
                    dst_d  = dst;
                    srca_d = srca;
                    srcb_d = srcb;
                    imm_d  = imm;
                    if (opcode_e'(opcode) == OP_NOP) begin
                        done_d = 1'b1;
                    end else if (opcode_e'(opcode) == OP_LDI) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_value;
                if (is_flag_op(op_q)) begin
                    zero_d  = alu_zero;
                    carry_d = alu_carry;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are pure state decodes so reset removes them immediately.
    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rf_write    = (state_q == ST_WRITE);
    assign rf_xaddr    = dst_q;
    assign rf_aaddr    = srca_q;
    assign rf_baddr    = srcb_q;
    assign rf_x        = result_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer with a small registered-read register file and a scoreboard model.
module tb_rf_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] opcode = 3'd0;
    logic [1:0] dst = 2'd0;
    logic [1:0] srca = 2'd0;
    logic [1:0] srcb = 2'd0;
    logic [7:0] imm = 8'd0;
    logic       rf_write;
    logic [1:0] rf_xaddr, rf_aaddr, rf_baddr;
    logic [7:0] rf_x;
    logic [7:0] rf_a, rf_b;
    logic       done;
    logic [7:0] result;
    logic       zero, carry, busy;

    logic       rf_clear = 1'b1;
    logic [7:0] rf_mem [4];
    int         cyc = 0;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic       zero;
        logic       carry;
    } wr_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] result;
        logic       zero;
        logic       carry;
    } done_exp_t;

    wr_exp_t   wq[$];
    done_exp_t dq[$];

    logic [7:0] m [4];
    logic [7:0] m_result = 8'd0;
    logic       m_zero = 1'b0;
    logic       m_carry = 1'b0;

    int checks = 0;
    int errors = 0;

    rf_sequencer #(
        .DATA_W (8),
        .ADDR_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .dst         (dst),
        .srca        (srca),
        .srcb        (srcb),
        .imm         (imm),
        .rf_write    (rf_write),
        .rf_xaddr    (rf_xaddr),
        .rf_aaddr    (rf_aaddr),
        .rf_baddr    (rf_baddr),
        .rf_x        (rf_x),
        .rf_a        (rf_a),
        .rf_b        (rf_b),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .carry       (carry),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file contents survive the sequencer reset; only rf_clear wipes them.
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 8'd0;
        end else if (rf_write) begin
            rf_mem[rf_xaddr] <= rf_x;
        end
        rf_a <= rf_mem[rf_aaddr];
        rf_b <= rf_mem[rf_baddr];
    end

    task automatic monitor();
        wr_exp_t   we;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (rf_write === 1'b1) begin
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_write got addr=%0d data=%h, required no write", rf_xaddr, rf_x);
                    end else begin
                        we = wq.pop_front();
                        if (rf_xaddr !== we.addr || rf_x !== we.data || zero !== we.zero || carry !== we.carry) begin
                            errors++;
                            $display("[TB] FAIL write got addr=%0d data=%h z=%b c=%b, required addr=%0d data=%h z=%b c=%b",
                                     rf_xaddr, rf_x, zero, carry, we.addr, we.data, we.zero, we.carry);
                        end
                    end
                end
                if (done === 1'b1) begin
                    checks++;
                    if (dq.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_done got done=1 at cycle %0d, required 0", cyc);
                    end else begin
                        de = dq.pop_front();
                        if (cyc != de.cyc || result !== de.result || zero !== de.zero || carry !== de.carry) begin
                            errors++;
                            $display("[TB] FAIL done got cyc=%0d res=%h z=%b c=%b, required cyc=%0d res=%h z=%b c=%b",
                                     cyc, result, zero, carry, de.cyc, de.result, de.zero, de.carry);
                        end
                    end
                end
            end
        end
    endtask

    // Drives one instruction, waits for IDLE, and pushes the model's expectations at accept.
    task automatic send(input logic [2:0] op, input logic [1:0] d, input logic [1:0] a,
                        input logic [1:0] b, input logic [7:0] im, input bit hold, output int acc);
        wr_exp_t   we;
        done_exp_t de;
        logic [8:0] w;
        logic [7:0] x;
        int n;
        int lat;
        acc = -1;
        @(negedge clk);
        n = 0;
        while (instr_ready !== 1'b1 && n < 40) begin
            opcode = 3'($urandom);
            dst    = 2'($urandom);
            srca   = 2'($urandom);
            srcb   = 2'($urandom);
            imm    = 8'($urandom);
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout got ready=%b, required 1", instr_ready);
        end else begin
            opcode = op; dst = d; srca = a; srcb = b; imm = im;
            instr_valid = 1'b1;
            acc = cyc + 1;
            w = 9'd0;
            x = 8'd0;
            lat = 4;
            case (op)
                3'd1: w = {1'b0, m[a]} + {1'b0, m[b]};
                3'd2: w = {1'b0, m[a]} - {1'b0, m[b]};
                3'd3: w = {1'b0, m[a] & m[b]};
                3'd4: w = {1'b0, m[a] | m[b]};
                3'd5: w = {1'b0, m[a] ^ m[b]};
                default: w = 9'd0;
            endcase
            if (op >= 3'd1 && op <= 3'd5) begin
                x = w[7:0];
                m_zero = (w[7:0] == 8'd0);
                m_carry = w[8];
            end else if (op == 3'd6) begin
                x = im;
                lat = 3;
            end else if (op == 3'd7) begin
                x = m[a];
            end else begin
                lat = 1;
            end
            if (op != 3'd0) begin
                m[d] = x;
                m_result = x;
                we.addr = d; we.data = x; we.zero = m_zero; we.carry = m_carry;
                wq.push_back(we);
            end
            de.cyc = acc + lat - 1; de.result = m_result; de.zero = m_zero; de.carry = m_carry;
            dq.push_back(de);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            instr_valid = 1'b0;
            opcode = 3'($urandom);
            dst    = 2'($urandom);
            srca   = 2'($urandom);
            imm    = 8'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || dq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout got pending w=%0d d=%0d, required 0", wq.size(), dq.size());
        end
    endtask

    task automatic test_reset();
        int rel;
        int acc;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || rf_write !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got ready=%b busy=%b wr=%b done=%b, required 1 0 0 0", instr_ready, busy, rf_write, done);
        end
        checks++;
        if (result !== 8'd0 || zero !== 1'b0 || carry !== 1'b0 || rf_x !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got res=%h z=%b c=%b x=%h, required 00 0 0 00", result, zero, carry, rf_x);
        end
        checks++;
        if (rf_xaddr !== 2'd0 || rf_aaddr !== 2'd0 || rf_baddr !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_addr got %0d %0d %0d, required 0 0 0", rf_xaddr, rf_aaddr, rf_baddr);
        end
        for (int i = 0; i < 4; i++) m[i] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rf_clear = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        rel = cyc;
        send(3'd6, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0, acc);
        checks++;
        if (acc != rel + 1) begin
            errors++;
            $display("[TB] FAIL first_accept got edge %0d, required %0d", acc, rel + 1);
        end
    endtask

    task automatic test_add();
        int acc;
        send(3'd6, 2'd2, 2'd0, 2'd0, 8'h03, 1'b0, acc);
        send(3'd1, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, acc);
        drain();
        checks++;
        if (rf_mem[3] !== 8'h08 || zero !== 1'b0 || carry !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add got r3=%h z=%b c=%b, required 08 0 0", rf_mem[3], zero, carry);
        end
    endtask

    task automatic test_sub();
        int acc;
        send(3'd2, 2'd0, 2'd2, 2'd1, 8'h00, 1'b0, acc);
        drain();
        checks++;
        if (rf_mem[0] !== 8'hFE || zero !== 1'b0 || carry !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub got r0=%h z=%b c=%b, required fe 0 1", rf_mem[0], zero, carry);
        end
    endtask

    task automatic test_overflow_mov();
        int acc;
        send(3'd6, 2'd1, 2'd0, 2'd0, 8'hFF, 1'b0, acc);
        send(3'd6, 2'd2, 2'd0, 2'd0, 8'h01, 1'b0, acc);
        send(3'd1, 2'd1, 2'd1, 2'd2, 8'h00, 1'b0, acc);
        send(3'd7, 2'd2, 2'd1, 2'd3, 8'h00, 1'b0, acc);
        drain();
        checks++;
        if (rf_mem[1] !== 8'h00 || rf_mem[2] !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_mov got r1=%h r2=%h z=%b c=%b, required 00 00 1 1", rf_mem[1], rf_mem[2], zero, carry);
        end
    endtask

    task automatic test_nop_logic();
        int acc;
        send(3'd0, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            send(3'd6, 2'd1, 2'd0, 2'd0, 8'($urandom), 1'b0, acc);
            send(3'd6, 2'd2, 2'd0, 2'd0, 8'($urandom), 1'b0, acc);
            send(3'(3 + i), 2'(i), 2'd1, 2'd2, 8'h00, 1'b0, acc);
            send(3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, acc);
        end
        drain();
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("[TB] FAIL logic_carry got %b, required 0", carry);
        end
    endtask

    task automatic test_reset_abort();
        int acc;
        logic [7:0] saved;
        saved = m[3];
        send(3'd1, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, acc);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || rf_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_ctrl got ready=%b wr=%b busy=%b done=%b, required 1 0 0 0", instr_ready, rf_write, busy, done);
        end
        checks++;
        if (result !== 8'd0 || zero !== 1'b0 || carry !== 1'b0 || rf_xaddr !== 2'd0) begin
            errors++;
            $display("[TB] FAIL abort_data got res=%h z=%b c=%b xa=%0d, required 00 0 0 0", result, zero, carry, rf_xaddr);
        end
        void'(wq.pop_back());
        void'(dq.pop_back());
        m[3] = saved;
        m_result = 8'd0;
        m_zero = 1'b0;
        m_carry = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (rf_mem[3] !== saved) begin
            errors++;
            $display("[TB] FAIL abort_r3 got %h, required %h", rf_mem[3], saved);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        send(3'd6, 2'd1, 2'd0, 2'd0, 8'($urandom), 1'b0, a0);
        send(3'd6, 2'd2, 2'd0, 2'd0, 8'($urandom), 1'b0, a0);
        send(3'd1, 2'd2, 2'd2, 2'd1, 8'h00, 1'b1, a0);
        send(3'd2, 2'd2, 2'd2, 2'd1, 8'h00, 1'b1, a1);
        send(3'd5, 2'd2, 2'd2, 2'd1, 8'h00, 1'b0, a2);
        drain();
        checks++;
        if (a1 != a0 + 4 || a2 != a1 + 4) begin
            errors++;
            $display("[TB] FAIL b2b_accept got edges %0d %0d %0d, required spacing 4", a0, a1, a2);
        end
        checks++;
        if (rf_mem[2] !== m[2]) begin
            errors++;
            $display("[TB] FAIL b2b_r2 got %h, required %h", rf_mem[2], m[2]);
        end
    endtask

    task automatic test_final_contents();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rf_mem[i] !== m[i]) begin
                errors++;
                $display("[TB] FAIL final_r%0d got %h, required %h", i, rf_mem[i], m[i]);
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_add();
        test_sub();
        test_overflow_mov();
        test_nop_logic();
        test_reset_abort();
        test_back_to_back();
        test_final_contents();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
